// File: rtl/dmem_uart_dumper.sv
// ---------------------------------------------------------------------------
// dmem_uart_dumper
//
// Reads NUM_WORDS consecutive 32-bit words from data memory over a Wishbone
// read port, starting at BASE_ADDR. Each word goes out on a UART 8N1 line as
// 4 bytes, least significant byte first. The block is muxed onto the DMEM
// port while the core is idle, so the host can dump the results of a run.
//
// Ports:
//   clk_100mhz   : clock
//   i_rst        : asynchronous, active-high reset
//   i_start      : one-cycle dump request (ignored while o_busy=1)
//   o_wb_cyc     : bus cycle active (REQ and WAIT_ACK only)
//   o_wb_stb     : read request (REQ only)
//   o_wb_we      : always 0 (read-only initiator)
//   o_wb_addr    : byte address of the current word
//   o_wb_sel     : always 4'b1111
//   i_wb_ack     : read data valid
//   i_wb_stall   : responder not accepting the request
//   i_wb_data    : read data
//   o_tx         : UART serial out, idles high
//   o_busy       : dump in progress
//   o_done       : one-cycle pulse on successful completion
//   o_err        : sticky ack-timeout flag, cleared by next accepted i_start
//
// Handshake: a request is presented with cyc=1/stb=1 and is accepted on the
// first rising edge where i_wb_stall=0. Only one request is outstanding at a
// time. The ack may arrive in the acceptance cycle itself or any later cycle
// up to ACK_TIMEOUT cycles after acceptance; acks seen at any other time are
// ignored.
// ---------------------------------------------------------------------------
module dmem_uart_dumper #(
    parameter logic [31:0] BASE_ADDR    = 32'd0,
    parameter int          NUM_WORDS    = 11,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          ACK_TIMEOUT  = 255
) (
    input  logic        clk_100mhz,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_TX       = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [9:0]        WORD_LAST = 10'(NUM_WORDS - 1);
    localparam logic [7:0]        TMO_LAST  = 8'(ACK_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [31:0]       r_addr;
    logic [9:0]        r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [3:0]        r_bit_idx;
    logic [BAUD_W-1:0] r_baud;
    logic [7:0]        r_tmo;
    logic [31:0]       r_word;
    logic [9:0]        r_frame;
    logic              r_tx;
    logic              r_err;

    logic [7:0]        w_byte;

    always_comb begin
        w_byte = r_word[7:0];
        case (r_byte_idx)
            2'd0:    w_byte = r_word[7:0];
            2'd1:    w_byte = r_word[15:8];
            2'd2:    w_byte = r_word[23:16];
            default: w_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_addr     <= BASE_ADDR;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_baud     <= '0;
            r_tmo      <= '0;
            r_word     <= '0;
            r_frame    <= '1;
            r_tx       <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_err      <= 1'b0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_addr     <= BASE_ADDR;
                        r_state    <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Timeout counting starts at acceptance; stalled cycles are free.
                    if (!i_wb_stall) begin
                        r_tmo <= '0;
                        if (i_wb_ack) begin
                            r_word  <= i_wb_data;
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_WAIT_ACK;
                        end
                    end
                end

                S_WAIT_ACK: begin
                    if (i_wb_ack) begin
                        r_word  <= i_wb_data;
                        r_state <= S_LOAD;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end

                S_LOAD: begin
                    // Frame is sent from bit 0: start, d0..d7, stop.
                    r_frame   <= {1'b1, w_byte, 1'b0};
                    r_bit_idx <= '0;
                    r_baud    <= '0;
                    r_state   <= S_TX;
                end

                S_TX: begin
                    // A new bit is driven whenever the baud counter wraps to 0,
                    // so each bit is held exactly CLKS_PER_BIT cycles.
                    if (r_baud == '0) begin
                        r_tx <= r_frame[r_bit_idx];
                    end
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_idx == 4'd9) begin
                            if (r_byte_idx != 2'd3) begin
                                r_byte_idx <= r_byte_idx + 2'd1;
                                r_state    <= S_LOAD;
                            end else begin
                                r_state <= S_NEXT;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_NEXT: begin
                    r_byte_idx <= '0;
                    if (r_word_idx == WORD_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_word_idx <= r_word_idx + 10'd1;
                        r_addr     <= r_addr + 32'd4;
                        r_state    <= S_REQ;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wb_cyc  = (r_state == S_REQ) || (r_state == S_WAIT_ACK);
    assign o_wb_stb  = (r_state == S_REQ);
    assign o_wb_we   = 1'b0;
    assign o_wb_sel  = 4'b1111;
    assign o_wb_addr = r_addr;
    assign o_tx      = r_tx;
    assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done    = (r_state == S_DONE);
    assign o_err     = r_err;

endmodule

// File: tb/tb_dmem_uart_dumper.sv
// ---------------------------------------------------------------------------
// tb_dmem_uart_dumper
//
// Bench for dmem_uart_dumper built with BASE_ADDR=0x28, NUM_WORDS=2,
// CLKS_PER_BIT=4, ACK_TIMEOUT=8. A Wishbone responder model serves two
// memory words with configurable stall/ack latency, and a UART decoder
// rebuilds the byte stream. Full dumps come from a table of scenarios;
// timeout, frame shape, busy-ignore and mid-frame reset are hand sequences.
// ---------------------------------------------------------------------------
module tb_dmem_uart_dumper;

    logic        clk_100mhz = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_data;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    dmem_uart_dumper #(
        .BASE_ADDR   (32'h0000_0028),
        .NUM_WORDS   (2),
        .CLKS_PER_BIT(4),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_addr (o_wb_addr),
        .o_wb_sel  (o_wb_sel),
        .i_wb_ack  (i_wb_ack),
        .i_wb_stall(i_wb_stall),
        .i_wb_data (i_wb_data),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    // ---------------- clock ----------------
    always #5 clk_100mhz = ~clk_100mhz;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- responder model ----------------
    logic [31:0] mem0, mem1;
    int          stall_left = 0;
    int          lat_cfg    = 1;
    bit          no_ack     = 0;
    int          pend_cnt   = 0;
    logic [31:0] pend_data;
    int          stb_run    = 0;
    int          done_cnt   = 0;
    int          tx_low_cnt = 0;
    logic [31:0] addr_q[$];
    int          stb_q[$];
    logic [7:0]  bytes_q[$];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a == 32'h28)      return mem0;
        else if (a == 32'h2C) return mem1;
        else                  return 32'hBAD0_BAD0;
    endfunction

    initial begin : responder
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_data  = '0;
        forever begin
            @(negedge clk_100mhz);
            i_wb_ack   = 1'b0;
            i_wb_stall = 1'b0;
            if (o_done) done_cnt++;
            if (!o_tx)  tx_low_cnt++;
            if (i_rst) begin
                pend_cnt = 0;
                stb_run  = 0;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    i_wb_ack  = 1'b1;
                    i_wb_data = pend_data;
                end
            end else if (o_wb_stb) begin
                stb_run++;
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    // Accepted on the coming rising edge.
                    stb_q.push_back(stb_run);
                    stb_run = 0;
                    addr_q.push_back(o_wb_addr);
                    pend_data = mem_read(o_wb_addr);
                    if (!no_ack) begin
                        if (lat_cfg == 0) begin
                            i_wb_ack  = 1'b1;
                            i_wb_data = pend_data;
                        end else begin
                            pend_cnt = lat_cfg;
                        end
                    end
                end
            end
        end
    end

    // ---------------- UART decoder (4 clocks per bit) ----------------
    logic       dec_prev = 1'b1;
    logic [7:0] dec_byte;

    initial begin : uart_decoder
        forever begin
            @(negedge clk_100mhz);
            if (dec_prev && !o_tx) begin
                // Falling edge seen half a cycle into the start bit.
                repeat (5) @(negedge clk_100mhz);
                for (int b = 0; b < 8; b++) begin
                    dec_byte[b] = o_tx;
                    if (b < 7) repeat (4) @(negedge clk_100mhz);
                end
                repeat (4) @(negedge clk_100mhz);
                check("stop_bit", {63'd0, o_tx}, 64'd1);
                bytes_q.push_back(dec_byte);
            end
            dec_prev = o_tx;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          stall;      // stall cycles on the first request
        int          lat;        // ack latency after acceptance (0 = same cycle)
        logic [31:0] m0;
        logic [31:0] m1;
        logic [63:0] exp_bytes;  // byte k in bits [8k+7:8k]
        int          exp_stb;    // cycles stb is high for the first request
        int          exp_cycles; // start edge to o_done
    } vec_t;

    vec_t vecs[4];

    // Per word: (1+stall) REQ + lat WAIT_ACK + 1 LOAD + 4*41-1 TX/gaps + 1 NEXT.
    initial begin
        vecs[0] = '{"basic",   0, 1, 32'h4433_2211, 32'h8877_6655, 64'h8877_6655_4433_2211, 1, 334};
        vecs[1] = '{"stall5",  5, 1, 32'h4433_2211, 32'h8877_6655, 64'h8877_6655_4433_2211, 6, 339};
        vecs[2] = '{"zerolat", 0, 0, 32'h0000_00A5, 32'hDEAD_BEEF, 64'hDEAD_BEEF_0000_00A5, 1, 332};
        vecs[3] = '{"lat3",    2, 3, 32'h0102_0304, 32'hF0E0_D0C0, 64'hF0E0_D0C0_0102_0304, 3, 340};
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk_100mhz);
        i_start = 1'b1;
        @(negedge clk_100mhz);
        i_start = 1'b0;
    endtask

    task automatic setup(input vec_t v);
        stall_left = v.stall;
        lat_cfg    = v.lat;
        no_ack     = 1'b0;
        mem0       = v.m0;
        mem1       = v.m1;
        done_cnt   = 0;
        tx_low_cnt = 0;
        addr_q.delete();
        stb_q.delete();
        bytes_q.delete();
    endtask

    task automatic wait_done(output int n, output int busy_low);
        n = 0;
        busy_low = 0;
        while (!o_done && n < 2000) begin
            @(negedge clk_100mhz);
            n++;
            if (!o_busy && !o_done) busy_low++;
        end
    endtask

    task automatic final_checks(input vec_t v);
        logic [7:0] got;
        repeat (10) @(negedge clk_100mhz);
        check({v.name, "_done_cnt"}, done_cnt, 1);
        check({v.name, "_err"}, {63'd0, o_err}, 0);
        check({v.name, "_busy_after"}, {63'd0, o_busy}, 0);
        check({v.name, "_req_cnt"}, addr_q.size(), 2);
        check({v.name, "_addr0"}, (addr_q.size() > 0) ? addr_q[0] : 32'hFFFF_FFFF, 32'h28);
        check({v.name, "_addr1"}, (addr_q.size() > 1) ? addr_q[1] : 32'hFFFF_FFFF, 32'h2C);
        check({v.name, "_stb_len"}, (stb_q.size() > 0) ? stb_q[0] : -1, v.exp_stb);
        check({v.name, "_byte_cnt"}, bytes_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", v.name, i), {56'd0, got}, {56'd0, v.exp_bytes[8*i +: 8]});
        end
    endtask

    task automatic run_vector(input vec_t v);
        int n, busy_low;
        setup(v);
        pulse_start();
        check({v.name, "_err_clr"}, {63'd0, o_err}, 0);
        check({v.name, "_busy"}, {63'd0, o_busy}, 1);
        wait_done(n, busy_low);
        check({v.name, "_cycles"}, n, v.exp_cycles);
        check({v.name, "_busy_gap"}, busy_low, 0);
        final_checks(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int         n, busy_low;
        logic [9:0] frame_bits;

        i_rst   = 1'b1;
        i_start = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        check("rst_tx",   {63'd0, o_tx},     1);
        check("rst_cyc",  {63'd0, o_wb_cyc}, 0);
        check("rst_stb",  {63'd0, o_wb_stb}, 0);
        check("rst_addr", o_wb_addr,         32'h28);
        check("rst_busy", {63'd0, o_busy},   0);
        check("rst_done", {63'd0, o_done},   0);
        check("rst_err",  {63'd0, o_err},    0);
        check("we_tied",  {63'd0, o_wb_we},  0);
        check("sel_tied", {60'd0, o_wb_sel}, 4'hF);
        i_rst = 1'b0;
        repeat (2) @(negedge clk_100mhz);

        // Table-driven full dumps.
        for (int k = 0; k < 4; k++) run_vector(vecs[k]);

        // Ack timeout: acceptance one edge after start, error 8 edges later.
        setup(vecs[0]);
        no_ack = 1'b1;
        pulse_start();
        n = 0;
        while (!o_err && n < 100) begin
            @(negedge clk_100mhz);
            n++;
        end
        check("tmo_cycles", n, 9);
        check("tmo_cyc",    {63'd0, o_wb_cyc}, 0);
        check("tmo_stb",    {63'd0, o_wb_stb}, 0);
        check("tmo_busy",   {63'd0, o_busy},   0);
        repeat (5) @(negedge clk_100mhz);
        check("tmo_err_sticky", {63'd0, o_err}, 1);
        check("tmo_no_done",    done_cnt,   0);
        check("tmo_tx_idle",    tx_low_cnt, 0);
        // Next start clears the error and dumps normally.
        run_vector(vecs[0]);

        // Zero-latency ack, frame shape of 0xA5.
        setup(vecs[2]);
        frame_bits = 10'b1101001010;
        pulse_start();
        n = 0;
        while (o_tx && n < 100) begin
            @(negedge clk_100mhz);
            n++;
        end
        check("zl_first_bit", n, 3);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("zl_frame_c%0d", i), {63'd0, o_tx}, {63'd0, frame_bits[i/4]});
            @(negedge clk_100mhz);
        end
        wait_done(n, busy_low);
        check("zl_done_seen", {63'd0, o_done}, 1);
        final_checks(vecs[2]);

        // Start pulse during byte 2 must be ignored.
        setup(vecs[0]);
        pulse_start();
        n = 0;
        while (bytes_q.size() < 2 && n < 1000) begin
            @(negedge clk_100mhz);
            n++;
        end
        repeat (10) @(negedge clk_100mhz);
        pulse_start();
        wait_done(n, busy_low);
        check("busy_ign_done_seen", {63'd0, o_done}, 1);
        final_checks(vecs[0]);

        // Reset during data bit 3 of the first byte.
        setup(vecs[0]);
        pulse_start();
        n = 0;
        while (o_tx && n < 100) begin
            @(negedge clk_100mhz);
            n++;
        end
        repeat (17) @(negedge clk_100mhz);
        check("mid_d3_low", {63'd0, o_tx}, 0);
        i_rst = 1'b1;
        #1;
        check("mid_rst_tx",   {63'd0, o_tx},     1);
        check("mid_rst_busy", {63'd0, o_busy},   0);
        check("mid_rst_cyc",  {63'd0, o_wb_cyc}, 0);
        check("mid_rst_addr", o_wb_addr,         32'h28);
        @(negedge clk_100mhz);
        i_rst = 1'b0;
        repeat (60) @(negedge clk_100mhz);
        run_vector(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
